// File: rtl/systolic_feeder.sv
// systolic_feeder: accepts activation rows over valid/ready and presents them
// diagonally skewed to the systolic array (column j lags column 0 by j cycles).
// It also generates the per-burst sign window and the result_valid/result_last
// strobes that line up with the array's result rows.
module systolic_feeder #(
   parameter int MATRIX_WIDTH = 4,
   parameter int RESULT_DELAY = MATRIX_WIDTH + 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [MATRIX_WIDTH-1:0][7:0]  in_data,
   input  logic                          in_signed,
   input  logic                          in_last,
   output logic [MATRIX_WIDTH-1:0][7:0]  systolic_data,
   output logic                          systolic_signed,
   output logic                          result_valid,
   output logic                          result_last,
   output logic                          busy
);

   localparam int CW = $clog2(MATRIX_WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DRAIN  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       drain_q, drain_d;
   logic                sign_q;
   logic [CW-1:0]       win_q;
   logic [MATRIX_WIDTH-1:0] occ_q;
   logic [RESULT_DELAY:0]   tag_v_q;
   logic [RESULT_DELAY:0]   tag_l_q;

   logic accept;
   logic first_row;

   assign accept    = in_valid && in_ready;
   // A row accepted while idle is always the first row of a new burst.
   assign first_row = accept && (state_q == S_IDLE);

   // State register and drain down-counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   // Next-state logic: the last row of a burst starts the drain period that
   // keeps the next burst's sign window from overlapping this one.
   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      case (state_q)
         S_IDLE, S_STREAM: begin
            if (accept) begin
               if (in_last) begin
                  if (MATRIX_WIDTH > 1) begin
                     state_d = S_DRAIN;
                     drain_d = CW'(MATRIX_WIDTH - 1);
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  state_d = S_STREAM;
               end
            end
         end
         S_DRAIN: begin
            drain_d = drain_q - CW'(1);
            if (drain_q <= CW'(1)) begin
               state_d = S_IDLE;
               drain_d = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            drain_d = '0;
         end
      endcase
   end

   // Sign latch and window counter: armed by the first row, open for
   // MATRIX_WIDTH cycles starting the cycle after acceptance.
   always_ff @(posedge clk) begin
      if (rst) begin
         sign_q <= 1'b0;
         win_q  <= '0;
      end else if (first_row) begin
         sign_q <= in_signed;
         win_q  <= CW'(MATRIX_WIDTH);
      end else if (win_q != '0) begin
         win_q  <= win_q - CW'(1);
      end
   end

   // Skew chains: column gi passes through gi+1 registers, so it appears
   // gi+1 cycles after acceptance. Idle cycles inject zeros.
   generate
      for (genvar gi = 0; gi < MATRIX_WIDTH; gi++) begin : g_skew
         logic [7:0] chain_q [gi+1];

         // Shift the column chain every cycle.
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int k = 0; k <= gi; k++) chain_q[k] <= '0;
            end else begin
               chain_q[0] <= accept ? in_data[gi] : 8'd0;
               for (int k = 1; k <= gi; k++) chain_q[k] <= chain_q[k-1];
            end
         end

         assign systolic_data[gi] = chain_q[gi];
      end
   endgenerate

   // Occupancy of the skew chains, tracked separately because real data
   // may legitimately be zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q <= '0;
      end else begin
         occ_q[0] <= accept;
         for (int k = 1; k < MATRIX_WIDTH; k++) occ_q[k] <= occ_q[k-1];
      end
   end

   // Result tag pipeline: one (valid, last) slot per cycle, delayed so the
   // strobe coincides with the array's result row.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_v_q <= '0;
         tag_l_q <= '0;
      end else begin
         tag_v_q[0] <= accept;
         tag_l_q[0] <= accept && in_last;
         for (int k = 1; k <= RESULT_DELAY; k++) begin
            tag_v_q[k] <= tag_v_q[k-1];
            tag_l_q[k] <= tag_l_q[k-1];
         end
      end
   end

   // Output decode from state and pipeline contents.
   always_comb begin
      in_ready        = 1'b0;
      busy            = 1'b0;
      systolic_signed = 1'b0;
      result_valid    = 1'b0;
      result_last     = 1'b0;
      in_ready        = !rst && (state_q != S_DRAIN);
      busy            = (state_q != S_IDLE) || (|occ_q) || (|tag_v_q);
      systolic_signed = sign_q && (win_q != '0);
      result_valid    = tag_v_q[RESULT_DELAY];
      result_last     = tag_v_q[RESULT_DELAY] && tag_l_q[RESULT_DELAY];
   end

endmodule
